chan_mux_scan: RTL

- Parametrised, registered N-channel, W-bit multiplexer with a built-in scan sequencer.
- Generalises the 4-bit 4:1 combinational mux family.
- Auto mode: steps through channels at a programmable rate, for time-multiplexed displays such as 7-segment digit scan.
- Manual mode: tracks an external select.
- Sits between per-channel data sources (BCD/segment encoders) and board pins (data bus plus one-hot channel enables).

---
 rtl/chan_mux_scan.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/chan_mux_scan.sv
// chan_mux_scan: registered NCH-channel, WIDTH-bit multiplexer with a scan
// sequencer. In auto mode the selected channel advances every DIV cycles;
// in manual mode it follows sel_in, ignoring out-of-range values.
// Optional anti-ghosting blanking: define CHAN_MUX_SCAN_BLANK_EN to add the
// BLANK parameter, which holds onehot at zero for BLANK cycles after every
// channel change.
module chan_mux_scan #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int DIV   = 100000,
`ifdef CHAN_MUX_SCAN_BLANK_EN
  parameter int BLANK = 2,
`endif
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel_in,
  input  logic [NCH*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]     out,
  output logic [SELW-1:0]      sel_out,
  output logic [NCH-1:0]       onehot,
  output logic                 tick,
  output logic                 valid
);

  localparam int CNTW  = $clog2(DIV);
  localparam int SELW1 = SELW + 1;

  localparam logic [CNTW-1:0]  CNT_MAX = CNTW'(DIV - 1);
  localparam logic [CNTW-1:0]  CNT_ONE = CNTW'(1);
  localparam logic [SELW-1:0]  SEL_MAX = SELW'(NCH - 1);
  localparam logic [SELW-1:0]  SEL_ONE = SELW'(1);
  localparam logic [SELW1-1:0] NCH_EXT = SELW1'(NCH);
  localparam logic [NCH-1:0]   OH_ONE  = NCH'(1);

  logic [SELW-1:0]  sel_q,    sel_d;
  logic [CNTW-1:0]  cnt_q,    cnt_d;
  logic [WIDTH-1:0] out_q,    out_d;
  logic [NCH-1:0]   onehot_q, onehot_d;
  logic             tick_q,   tick_d;
  logic             valid_q;

  // Unpacked view of the flat channel bus
  logic [WIDTH-1:0] ch [NCH];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign ch[gi] = data_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Sequencer next state: prescaler, channel select and advance pulse
  always_comb begin
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (en) begin
      if (mode) begin
        if (cnt_q == CNT_MAX) begin
          cnt_d  = '0;
          sel_d  = (sel_q == SEL_MAX) ? '0 : sel_q + SEL_ONE;
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        cnt_d = '0;
        // Out-of-range selects are dropped so sel never aliases a channel
        if ({1'b0, sel_in} < NCH_EXT) begin
          sel_d = sel_in;
        end
      end
    end
  end

`ifdef CHAN_MUX_SCAN_BLANK_EN
  localparam int BLW = $clog2(BLANK + 1);
  localparam logic [BLW-1:0] BL_LOAD = BLW'(BLANK);
  localparam logic [BLW-1:0] BL_ONE  = BLW'(1);

  logic [BLW-1:0] blank_q, blank_d;

  // Blanking window: reload on every channel change, otherwise count down
  always_comb begin
    blank_d = blank_q;
    if (sel_d != sel_q) begin
      blank_d = BL_LOAD;
    end else if (blank_q != '0) begin
      blank_d = blank_q - BL_ONE;
    end
  end

  // Blanking counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end

  // Output path: data shows the new channel at once, enable waits for blanking
  always_comb begin
    out_d    = ch[sel_q];
    onehot_d = (blank_q != '0) ? '0 : (OH_ONE << sel_q);
  end
`else
  // Output path: selected data and its channel enable
  always_comb begin
    out_d    = ch[sel_q];
    onehot_d = OH_ONE << sel_q;
  end
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      onehot_q <= '0;
      tick_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      onehot_q <= onehot_d;
      tick_q   <= tick_d;
      valid_q  <= 1'b1;
    end
  end

  assign out     = out_q;
  assign sel_out = sel_q;
  assign onehot  = onehot_q;
  assign tick    = tick_q;
  assign valid   = valid_q;

endmodule
